// File: rtl/snes_pad_responder_if.sv
// Bus between the SNES pad responder and whatever drives it: host-side serial lines,
// button inputs and frame status. SNES_PAD_TURBO_EN adds the turbo_mask signal.
`timescale 1ns/1ps
interface snes_pad_responder_if;
    logic        data_latch;
    logic        data_clock;
    logic [15:0] buttons_n;
`ifdef SNES_PAD_TURBO_EN
    logic [15:0] turbo_mask;
`endif
    logic        serial_data;
    logic        frame_strobe;
    logic [7:0]  frame_cnt;
    logic        active;

`ifdef SNES_PAD_TURBO_EN
    modport slave (
        input  data_latch, data_clock, buttons_n, turbo_mask,
        output serial_data, frame_strobe, frame_cnt, active
    );
    modport master (
        output data_latch, data_clock, buttons_n, turbo_mask,
        input  serial_data, frame_strobe, frame_cnt, active
    );
`else
    modport slave (
        input  data_latch, data_clock, buttons_n,
        output serial_data, frame_strobe, frame_cnt, active
    );
    modport master (
        output data_latch, data_clock, buttons_n,
        input  serial_data, frame_strobe, frame_cnt, active
    );
`endif
endinterface

// File: rtl/snes_pad_responder.sv
// Device-side SNES controller emulator: answers host latch/clock with 16 active-low bits.
// Optional turbo masking is enabled by defining SNES_PAD_TURBO_EN.
`timescale 1ns/1ps
module snes_pad_responder #(
    parameter int   SYNC_STAGES    = 2,
    parameter int   TIMEOUT_CYCLES = 200000,
    parameter logic FILL_BIT       = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset,
    snes_pad_responder_if.slave    bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATCHED,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] latch_sync_q;
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic                   latch_hist_q;
    logic                   clk_hist_q;
    logic [15:0]            shift_q;
    logic [3:0]             bit_cnt_q;
    logic                   serial_q;
    logic                   strobe_q;
    logic [7:0]             frame_cnt_q;
    logic                   active_q;
    logic [TW-1:0]          tmo_q;

    logic        latch_s;
    logic        clk_s;
    logic        latch_fall;
    logic        clk_rise;
    logic        clk_edge;
    logic [15:0] buttons_d;

    assign latch_s    = latch_sync_q[SYNC_STAGES-1];
    assign clk_s      = clk_sync_q[SYNC_STAGES-1];
    assign latch_fall = latch_hist_q & ~latch_s;
    assign clk_rise   = clk_s & ~clk_hist_q;
    assign clk_edge   = clk_s ^ clk_hist_q;

`ifdef SNES_PAD_TURBO_EN
    // Turbo buttons read released on odd frames; parity is taken before the increment.
    assign buttons_d = bus.buttons_n | (bus.turbo_mask & {16{frame_cnt_q[0]}});
`else
    assign buttons_d = bus.buttons_n;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            latch_sync_q <= '0;
            clk_sync_q   <= '1;
            latch_hist_q <= 1'b0;
            clk_hist_q   <= 1'b1;
        end else begin
            latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], bus.data_latch};
            clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], bus.data_clock};
            latch_hist_q <= latch_s;
            clk_hist_q   <= clk_s;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            shift_q     <= 16'hFFFF;
            bit_cnt_q   <= 4'd0;
            serial_q    <= 1'b1;
            strobe_q    <= 1'b0;
            frame_cnt_q <= 8'd0;
            active_q    <= 1'b0;
            tmo_q       <= '0;
        end else begin
            strobe_q <= 1'b0;
            // Latch has priority over everything, including a coincident clock edge.
            if (latch_s) begin
                state_q   <= S_LATCHED;
                active_q  <= 1'b1;
                shift_q   <= buttons_d;
                bit_cnt_q <= 4'd0;
                serial_q  <= buttons_d[0];
                tmo_q     <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        serial_q <= 1'b1;
                        active_q <= 1'b0;
                        tmo_q    <= '0;
                    end
                    S_LATCHED: begin
                        tmo_q <= '0;
                        if (latch_fall) begin
                            state_q     <= S_SHIFT;
                            active_q    <= 1'b1;
                            strobe_q    <= 1'b1;
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                        end
                    end
                    S_SHIFT: begin
                        if (clk_rise) begin
                            shift_q   <= {FILL_BIT, shift_q[15:1]};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            tmo_q     <= '0;
                            if (bit_cnt_q == 4'd15) begin
                                state_q  <= S_DONE;
                                active_q <= 1'b0;
                                serial_q <= FILL_BIT;
                            end else begin
                                serial_q <= shift_q[1];
                            end
                        end else if (clk_edge) begin
                            tmo_q <= '0;
                        end else if (tmo_q == TMO_LAST) begin
                            state_q  <= S_IDLE;
                            active_q <= 1'b0;
                            serial_q <= 1'b1;
                            tmo_q    <= '0;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    S_DONE: begin
                        serial_q <= FILL_BIT;
                        active_q <= 1'b0;
                        if (clk_edge) begin
                            tmo_q <= '0;
                        end else if (tmo_q == TMO_LAST) begin
                            state_q  <= S_IDLE;
                            serial_q <= 1'b1;
                            tmo_q    <= '0;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q  <= S_IDLE;
                        active_q <= 1'b0;
                        serial_q <= 1'b1;
                        tmo_q    <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.serial_data  = serial_q;
    assign bus.frame_strobe = strobe_q;
    assign bus.frame_cnt    = frame_cnt_q;
    assign bus.active       = active_q;

endmodule

// File: tb/tb_snes_pad_responder.sv
// Directed bench for snes_pad_responder: table of full frames plus multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_snes_pad_responder;

    localparam int TMO = 300;
    localparam int H   = 6;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   strobes;
    int   exp_frames;

    snes_pad_responder_if bus();

    snes_pad_responder #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(TMO),
        .FILL_BIT      (1'b0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(negedge clock) begin
        if (!reset && bus.frame_strobe) strobes++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic read_bits(input int nclk, output logic [15:0] cap);
        cap = 16'hFFFF;
        for (int i = 0; i < nclk; i++) begin
            bus.data_clock = 1'b0;
            cap[i] = bus.serial_data;
            cyc(H);
            bus.data_clock = 1'b1;
            cyc(H);
        end
    endtask

    task automatic run_frame(input logic [15:0] b, input int nclk, input int lh, input int w,
                             output logic [15:0] cap);
        bus.buttons_n  = b;
        bus.data_latch = 1'b1;
        cyc(lh);
        bus.data_latch = 1'b0;
        cyc(w);
        read_bits(nclk, cap);
    endtask

    typedef struct {
        logic [15:0] btn;
        logic [15:0] exp_cap;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t        vecs[6];
    logic [15:0] cap;
    int          sb;

    initial begin
        vecs[0] = '{16'hFEFE, 16'hFEFE, 8'd1};
        vecs[1] = '{16'h0FFF, 16'h0FFF, 8'd2};
        vecs[2] = '{16'h0000, 16'h0000, 8'd3};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 8'd4};
        vecs[4] = '{16'hA5C3, 16'hA5C3, 8'd5};
        vecs[5] = '{16'h8001, 16'h8001, 8'd6};

        n_checks = 0;
        n_fail = 0;
        strobes = 0;
        exp_frames = 0;
        bus.data_latch = 1'b0;
        bus.data_clock = 1'b1;
        bus.buttons_n  = 16'hFFFF;
`ifdef SNES_PAD_TURBO_EN
        bus.turbo_mask = 16'h0000;
`endif
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(10);

        check("reset_serial", {31'd0, bus.serial_data}, 32'd1);
        check("reset_frame_cnt", {24'd0, bus.frame_cnt}, 32'd0);
        check("reset_active", {31'd0, bus.active}, 32'd0);
        check("reset_no_strobe", strobes, 0);

        for (int v = 0; v < 6; v++) begin
            sb = strobes;
            run_frame(vecs[v].btn, 16, 8, 8, cap);
            exp_frames++;
            check($sformatf("frame%0d_capture", v), {16'd0, cap}, {16'd0, vecs[v].exp_cap});
            check($sformatf("frame%0d_cnt", v), {24'd0, bus.frame_cnt}, {24'd0, vecs[v].exp_cnt});
            check($sformatf("frame%0d_strobes", v), strobes - sb, 1);
        end

        // After the 16th rising edge: fill level, inactive, then timeout back to idle.
        check("done_fill", {31'd0, bus.serial_data}, 32'd0);
        check("done_inactive", {31'd0, bus.active}, 32'd0);
        cyc(200);
        check("before_timeout_fill", {31'd0, bus.serial_data}, 32'd0);
        cyc(150);
        check("after_timeout_idle", {31'd0, bus.serial_data}, 32'd1);

        // Restart mid-frame after 5 clocks with new buttons.
        run_frame(16'hFFFF, 5, 8, 8, cap);
        check("midframe_active", {31'd0, bus.active}, 32'd1);
        run_frame(16'h0FFF, 16, 8, 8, cap);
        exp_frames += 2;
        check("restart_capture", {16'd0, cap}, 32'h0FFF);
        check("restart_cnt", {24'd0, bus.frame_cnt}, exp_frames & 32'hFF);

        // Latch rise and clock rise presented together: latch wins, bit 0 re-presented.
        run_frame(16'hAAAA, 0, 4, 8, cap);
        bus.data_clock = 1'b0;
        cyc(H);
        bus.data_latch = 1'b1;
        bus.data_clock = 1'b1;
        cyc(6);
        bus.data_latch = 1'b0;
        cyc(8);
        exp_frames += 2;
        check("coincident_bit0", {31'd0, bus.serial_data}, 32'd0);
        read_bits(16, cap);
        check("coincident_capture", {16'd0, cap}, 32'hAAAA);

`ifdef SNES_PAD_TURBO_EN
        bus.turbo_mask = 16'h0100;
        for (int f = 0; f < 4; f++) begin
            logic [15:0] exp_t;
            exp_t = exp_frames[0] ? 16'hFFFF : 16'hFEFF;
            run_frame(16'hFEFF, 16, 8, 8, cap);
            exp_frames++;
            check($sformatf("turbo%0d_capture", f), {16'd0, cap}, {16'd0, exp_t});
        end
        bus.turbo_mask = 16'h0000;
`endif

        // Short frames until the counter wraps.
        while ((exp_frames % 256) != 255) begin
            run_frame(16'hFFFF, 0, 4, 4, cap);
            exp_frames++;
        end
        check("pre_wrap_cnt", {24'd0, bus.frame_cnt}, 32'd255);
        run_frame(16'hFFFF, 0, 4, 4, cap);
        exp_frames++;
        check("wrap_cnt", {24'd0, bus.frame_cnt}, 32'd0);
        check("total_strobes", strobes, exp_frames);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snes_pad_responder.md
Name: snes_pad_responder

Overview:
Device-side SNES controller emulator. It answers a console or host that drives data_latch and data_clock, shifting 16 active-low button bits out on serial_data in SNES bit order. It sits between the GBA input logic or a test harness and an external SNES controller port. It also serves as the loopback bench model for the host-side pad reader.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on data_latch and data_clock (minimum 2).
TIMEOUT_CYCLES, 200000, clock cycles without a data_clock edge, while in SHIFT or DONE, before returning to IDLE (2 ms at 100 MHz).
FILL_BIT, 1'b0, level driven on serial_data after all 16 bits have been shifted out.

Ports:
clock  input  1  system clock (100 MHz)
reset  input  1  asynchronous, active-high
data_latch  input  1  latch from host, asynchronous to clock
data_clock  input  1  shift clock from host, idles high, asynchronous to clock
buttons_n  input  16  button levels, active-low: [0]B [1]Y [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right [8]A [9]X [10]L [11]R [15:12] ID bits
serial_data  output  1  registered serial output to host
frame_strobe  output  1  one-cycle pulse on the synchronized falling edge of data_latch
frame_cnt  output  8  count of completed latches, wraps 255->0
active  output  1  high in LATCHED or SHIFT

Behaviour:
- Reset (async): state IDLE, shift_reg=16'hFFFF, bit_cnt=0, serial_data=1, frame_strobe=0, frame_cnt=0, timeout counter=0, synchronizer flops and edge-history flops=0 for latch and 1 for clock.
- Inputs pass through SYNC_STAGES flops, then one history flop for edge detect. An input level first sampled at edge N is reflected in serial_data/state at edge N+SYNC_STAGES.
- States:
  - IDLE: serial_data=1. Clock edges ignored.
  - LATCHED: shift_reg<=effective buttons every cycle; bit_cnt<=0; serial_data<=effective buttons[0]. Clock edges ignored.
  - SHIFT: on synced data_clock rising edge, shift_reg shifts right with FILL_BIT in at [15], bit_cnt++, serial_data<=next shift_reg[0]. Falling edges do not change anything (host samples there).
  - DONE: serial_data=FILL_BIT.
- Transitions:
  - any state with synced latch high -> LATCHED (restart mid-frame is legal; partial frame discarded).
  - LATCHED with latch falling -> SHIFT; frame_strobe=1 for that cycle; frame_cnt++.
  - SHIFT with rising edge and bit_cnt==15 -> DONE.
  - SHIFT or DONE with timeout counter==TIMEOUT_CYCLES-1 -> IDLE.
- Timeout counter: cleared on any synced clock edge, on latch high, and in IDLE. Otherwise increments in SHIFT/DONE. Width is $clog2(TIMEOUT_CYCLES)+1.
- Simultaneous latch-high and clock rising edge: latch wins, no shift.
- Bit n (0..15) is stable on serial_data from before the host's (n+1)th falling edge until after the following rising edge, given host half-periods >= SYNC_STAGES+2 cycles.
- active=1 exactly in LATCHED or SHIFT.

Optional Feature:
SNES_PAD_TURBO_EN
- Defined: adds input turbo_mask[15:0]. Effective buttons = buttons_n | (turbo_mask & {16{frame_cnt[0]}}). Masked pressed buttons therefore read released on odd frames. The load uses the frame_cnt value before the increment.
- Undefined: port absent; effective buttons = buttons_n.

Test Plan:
- Reset only -> serial_data=1, frame_cnt=0, active=0, frame_strobe never pulses.
- buttons_n=16'hFEFE; 12 us latch, 6 us wait, then 16 clocks at 6 us low / 6 us high; sample at falling edges -> captured 16'hFEFE, frame_cnt=1, one frame_strobe pulse.
- After the 16th rising edge -> serial_data=0 (FILL_BIT); after 200000 idle cycles -> state IDLE, serial_data=1.
- Latch reasserted after 5 clocks with buttons_n changed to 16'h0FFF -> new frame reads 16'h0FFF from bit 0; frame_cnt increments once per latch fall.
- Latch rise and clock rise arriving on the same edge -> no shift, bit 0 re-presented; 256 frames -> frame_cnt wraps to 0.
- SNES_PAD_TURBO_EN, turbo_mask=16'h0100, buttons_n=16'hFEFF -> frame 0 reads bit8=0, frame 1 reads bit8=1, alternating.
